// File: rtl/imuldiv_int_div_iterative_if.sv
// imuldiv_int_div_iterative_if: val/rdy request and response channels of the iterative divider.
interface imuldiv_int_div_iterative_if;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;
    modport master (
        output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
        input  divreq_rdy, divresp_msg_result, divresp_val
    );
    modport slave (
        input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
        output divreq_rdy, divresp_msg_result, divresp_val
    );
endinterface

// File: rtl/imuldiv_int_div_iterative.sv
// imuldiv_int_div_iterative: 32-step restoring divider returning {remainder, quotient}.
// IMULDIV_DIV_ZERO_BYPASS_EN sends zero-divisor requests straight to DONE.
module imuldiv_int_div_iterative (
    input logic clk,
    input logic reset,
    imuldiv_int_div_iterative_if.slave io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [4:0]  cnt;
    logic        sign_a, sign_b, dz;
    logic [31:0] a_r, rem, quo, dvs;
    logic [31:0] r, q;
    logic [32:0] d;
    logic        go, sa_in, sb_in, skip;
    assign go    = io.divreq_val & io.divreq_rdy;
    assign sa_in = io.divreq_msg_a[31] & ~io.divreq_msg_fn;
    assign sb_in = io.divreq_msg_b[31] & ~io.divreq_msg_fn;
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
    assign skip = io.divreq_msg_b == 32'd0;
`else
    assign skip = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = skip ? DONE : CALC;
            CALC:    if (cnt == 5'd31) state_n = DONE;
            DONE:    if (io.divresp_rdy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign {r, q} = {rem, quo} << 1;
    assign d      = {1'b0, r} - {1'b0, dvs};
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            a_r    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
        end else if (state == IDLE && go) begin
            cnt    <= '0;
            sign_a <= sa_in;
            sign_b <= sb_in;
            dz     <= io.divreq_msg_b == 32'd0;
            a_r    <= io.divreq_msg_a;
            rem    <= '0;
            quo    <= sa_in ? -io.divreq_msg_a : io.divreq_msg_a;
            dvs    <= sb_in ? -io.divreq_msg_b : io.divreq_msg_b;
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            rem <= d[32] ? r : d[31:0];
            quo <= d[32] ? q : {q[31:1], 1'b1};
        end
    end
    assign io.divreq_rdy         = state == IDLE;
    assign io.divresp_val        = state == DONE;
    assign io.divresp_msg_result = dz ? {a_r, 32'hFFFF_FFFF}
                                      : {sign_a ? -rem : rem, (sign_a ^ sign_b) ? -quo : quo};
endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// tb_imuldiv_int_div_iterative: directed and randomized checks against an integer-arithmetic model.
module tb_imuldiv_int_div_iterative;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    imuldiv_int_div_iterative_if io ();
    imuldiv_int_div_iterative dut (.clk(clk), .reset(reset), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic fn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, qt, rm;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        x  = fn ? {32'd0, a} : {{32{a[31]}}, a};
        y  = fn ? {32'd0, b} : {{32{b[31]}}, b};
        qt = x / y;
        rm = x % y;
        return {rm[31:0], qt[31:0]};
    endfunction
    task automatic run(input logic fn, input logic [31:0] a, input logic [31:0] b, input int hold);
        int n, lat;
        logic [63:0] exp;
        exp = model(fn, a, b);
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
        lat = (b == 32'd0) ? 1 : 33;
`else
        lat = 33;
`endif
        io.divreq_msg_fn = fn;
        io.divreq_msg_a  = a;
        io.divreq_msg_b  = b;
        io.divreq_val    = 1'b1;
        io.divresp_rdy   = 1'b0;
        n = 0;
        while (!io.divreq_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy", {63'd0, io.divreq_rdy}, 64'd1);
        @(posedge clk);
        #1;
        io.divreq_val    = 1'b0;
        io.divreq_msg_fn = 1'($urandom);
        io.divreq_msg_a  = $urandom;
        io.divreq_msg_b  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io.divresp_val && n < 100);
        chk("latency", 64'(n), 64'(lat));
        chk("result", io.divresp_msg_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", io.divresp_msg_result, exp);
            chk("hold_req_rdy", {63'd0, io.divreq_rdy}, 64'd0);
            chk("hold_val", {63'd0, io.divresp_val}, 64'd1);
        end
        io.divresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("post_req_rdy", {63'd0, io.divreq_rdy}, 64'd1);
        chk("post_val", {63'd0, io.divresp_val}, 64'd0);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] a, b;
        reset            = 1'b1;
        io.divreq_msg_fn = 1'b0;
        io.divreq_msg_a  = '0;
        io.divreq_msg_b  = '0;
        io.divreq_val    = 1'b0;
        io.divresp_rdy   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", {63'd0, io.divreq_rdy}, 64'd1);
        chk("rst_val", {63'd0, io.divresp_val}, 64'd0);
        chk("rst_result", io.divresp_msg_result, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_result", io.divresp_msg_result, 64'd0);
        run(1'b0, 32'd7, 32'd2, 0);
        run(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        run(1'b0, 32'd7, 32'hFFFF_FFFE, 0);
        run(1'b1, 32'hFFFF_FFFF, 32'h10, 0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run(1'b0, 32'd5, 32'd0, 0);
        run(1'b1, 32'd5, 32'd0, 0);
        run(1'b0, 32'hFFFF_FFFB, 32'd0, 1);
        run(1'b0, 32'd100, 32'd7, 5);
        run(1'b1, 32'hDEAD_BEEF, 32'd3, 0);
        io.divreq_msg_fn = 1'b0;
        io.divreq_msg_a  = 32'd9;
        io.divreq_msg_b  = 32'd4;
        io.divreq_val    = 1'b1;
        io.divresp_rdy   = 1'b1;
        @(posedge clk);
        #1;
        io.divreq_val = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_val", {63'd0, io.divresp_val}, 64'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abandon_val", {63'd0, io.divresp_val}, 64'd0);
        end
        chk("abandon_req_rdy", {63'd0, io.divreq_rdy}, 64'd1);
        run(1'b0, 32'd7, 32'd2, 0);
        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                3: b = $urandom_range(1, 255);
                default: ;
            endcase
            run(1'($urandom), a, b, $urandom_range(0, 2));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
